// File: rtl/multibyte_add_ctrl.sv
// Wide adder sequencer: streams byte pairs through an external 8-bit ripple adder,
// LSB first, chaining the carry through a register and presenting the assembled sum.
module multibyte_add_ctrl #(
  parameter  int NUM_BYTES = 4,
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [8*NUM_BYTES-1:0] op_a,
  input  logic [8*NUM_BYTES-1:0] op_b,
  input  logic                   cin_in,
  output logic [7:0]             adder_a,
  output logic [7:0]             adder_b,
  output logic                   adder_cin,
  input  logic [7:0]             adder_sum,
  input  logic                   adder_cout,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [8*NUM_BYTES-1:0] result,
  output logic                   res_cout,
  output logic                   overflow,
  output logic [1:0]             dbg_state
);

  localparam int W = 8 * NUM_BYTES;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // the producer holds valid and data stable until that edge.

  logic [1:0]       state;
  logic [W-1:0]     op_a_reg;
  logic [W-1:0]     op_b_reg;
  logic             carry_reg;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_a_reg  <= '0;
      op_b_reg  <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      result    <= '0;
      res_cout  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_valid) begin
            op_a_reg  <= op_a;
            op_b_reg  <= op_b;
            carry_reg <= cin_in;
            idx       <= '0;
            result    <= '0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          result[8*idx +: 8] <= adder_sum;
          carry_reg          <= adder_cout;
          idx                <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            // Signed overflow: operands agree in sign but the top sum byte does not.
            res_cout <= adder_cout;
            overflow <= (op_a_reg[W-1] == op_b_reg[W-1]) && (adder_sum[7] != op_a_reg[W-1]);
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    start_ready = (state == ST_IDLE);
    res_valid   = (state == ST_DONE);
    dbg_state   = state;
    adder_a     = 8'h00;
    adder_b     = 8'h00;
    adder_cin   = 1'b0;
    if (state == ST_RUN) begin
      adder_a   = op_a_reg[8*idx +: 8];
      adder_b   = op_b_reg[8*idx +: 8];
      adder_cin = carry_reg;
    end
  end

endmodule
